hc595_driver: RTL and testbench
===============================

Name: hc595_driver

Overview:
- Transmitter side of the 74HC595-style serial-in/parallel-out interface; loads a parallel word and clocks it out serially to an external shift/storage register chip.
- Generates SER, SRCLK, RCLK and active-low SRCLR with a programmable bit rate.
- Sits between lab-board logic (counters, FSMs) and an off-chip '595 chain driving LEDs or seven-segment displays.

Parameters:
- WIDTH, 8, bits per transfer (1..32); equals the total length of the '595 chain.
- CLK_DIV, 2, system clocks per half SRCLK period (>=1).

Ports:
- Clk  input  1  system clock; all logic on rising edge.
- Reset  input  1  synchronous, active-high reset.
- Data  input  WIDTH  word to send; sampled only when a Start is accepted.
- Start  input  1  request a transfer; level-sampled.
- Clear  input  1  request chain clear; level-sampled.
- Busy  output  1  high while a transfer or clear is in progress.
- Done  output  1  one-cycle pulse when a transfer or clear completes.
- Ser  output  1  serial data to the '595 SER pin, MSB first.
- Srclk  output  1  shift clock to the '595 SRCLK pin.
- Rclk  output  1  storage/latch clock to the '595 RCLK pin.
- Srclr_n  output  1  active-low shift-register clear to the '595 SRCLR pin.

Behaviour:
- Reset values (sampled Reset=1): Busy=0, Done=0, Ser=0, Srclk=0, Rclk=0, Srclr_n=1, FSM=IDLE, shift register=0, counters=0. Reset overrides every other input.
- FSM states: IDLE, SHIFT, LATCH, CLR, DONE.
- IDLE: all outputs at reset values.
  - Clear=1 -> CLR. Clear has priority over Start.
  - Otherwise Start=1 -> latch Data into the shift register, then SHIFT.
- SHIFT: each bit occupies 2*CLK_DIV cycles.
  - First CLK_DIV cycles: Srclk=0, Ser=current MSB.
  - Next CLK_DIV cycles: Srclk=1.
  - Ser changes only on the cycle Srclk falls (or the first SHIFT cycle), so it is stable for CLK_DIV cycles before each rising edge.
  - After bit WIDTH-1 completes its high phase -> LATCH.
- LATCH: Srclk=0, Rclk=1 for CLK_DIV cycles, Ser held at last bit, then -> DONE.
- CLR: Srclr_n=0 for CLK_DIV cycles, then Srclr_n=1 and Rclk=1 for CLK_DIV cycles (transfers zeros to outputs), then -> DONE.
- DONE: one cycle with Done=1, Busy=1, then -> IDLE.
- Busy=1 in every state except IDLE. Start and Clear are ignored while Busy. A Start held high re-triggers on the first IDLE cycle after DONE.
- Transfer latency: Busy high for exactly 2*CLK_DIV*WIDTH + CLK_DIV + 1 cycles, starting the cycle after Start is sampled. Example: WIDTH=8, CLK_DIV=2 gives 35 cycles.
- Clear latency: Busy high for 2*CLK_DIV + 1 cycles.
- Srclk and Rclk are never high in the same cycle. Rclk never rises while Srclr_n=0.
- Reset mid-transfer: the next edge forces reset values, so no Rclk pulse is issued and '595 outputs keep their previous word. The abandoned word is discarded, not resumed.
- Counters: the bit counter is ceil(log2(WIDTH+1)) wide and the phase counter ceil(log2(CLK_DIV+1)) wide. No wrap-around escapes into outputs.

Test Plan:
- Reset, then Start=1 for 1 cycle with Data=8'hA5 (WIDTH=8, CLK_DIV=2) -> 8 Srclk rising edges with Ser sampled at each edge = 1,0,1,0,0,1,0,1. Then Rclk high 2 cycles, Done pulse at cycle 35, Busy high 35 cycles. A behavioural '595 model shows 8'hA5.
- Clear=1 and Start=1 in the same IDLE cycle, Data=8'hFF -> CLR path taken: Srclr_n low 2 cycles, Rclk high 2 cycles, Done after 5 cycles, no Srclk edges, model outputs 8'h00.
- Start pulsed again at cycles 5 and 20 of an 8'h3C transfer -> both ignored, exactly 8 Srclk edges, single Done, model shows 8'h3C.
- Start held high continuously with Data=8'h01 then 8'h80 -> back-to-back transfers separated by exactly one IDLE cycle, model shows 8'h01 then 8'h80.
- Reset asserted one cycle at cycle 12 of a transfer of 8'hF0 after a prior 8'h0F -> all outputs at reset values next edge, no Rclk pulse, model still shows 8'h0F. A subsequent Start sends 8'hF0 correctly.
- WIDTH=1, CLK_DIV=1, Data=1'b1 -> Srclk high exactly 1 cycle with Ser=1, Rclk high 1 cycle, Busy high 4 cycles, Done at the 4th.

Source files
------------

// File: rtl/hc595_driver_if.sv
// Handshake and pin bundle between a word source and the '595 chain driver.
// The master side supplies words and requests; the slave side drives the chip pins.
interface hc595_driver_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] data;
   logic             start;
   logic             clear;
   logic             busy;
   logic             done;
   logic             ser;
   logic             srclk;
   logic             rclk;
   logic             srclr_n;

   modport master (
      output data, start, clear,
      input  busy, done, ser, srclk, rclk, srclr_n
   );

   modport slave (
      input  data, start, clear,
      output busy, done, ser, srclk, rclk, srclr_n
   );
endinterface

// File: rtl/hc595_driver.sv
// Serialises a parallel word into a 74HC595 chain, MSB first, then pulses RCLK.
// Also issues a chain clear (SRCLR low, then RCLK) that zeroes the '595 outputs.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | waiting; all pins at rest, Clear wins over Start
// S_SHIFT | per bit: CLK_DIV cycles SRCLK low, then CLK_DIV cycles high
// S_LATCH | RCLK high for CLK_DIV cycles, SER held at last bit
// S_CLR   | SRCLR low for CLK_DIV cycles, then RCLK high for CLK_DIV cycles
// S_DONE  | single-cycle completion pulse, still busy
module hc595_driver #(
   parameter int WIDTH   = 8,
   parameter int CLK_DIV = 2
) (
   input  logic                 clk_i,
   input  logic                 reset_i,
   hc595_driver_if.slave        ctl
);

   localparam int BIT_W = (WIDTH   > 1) ? $clog2(WIDTH + 1)   : 1;
   localparam int PH_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV + 1) : 1;

   localparam logic [BIT_W-1:0] BIT_LOAD = BIT_W'(WIDTH - 1);
   localparam logic [PH_W-1:0]  PH_LOAD  = PH_W'(CLK_DIV - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SHIFT = 3'd1,
      S_LATCH = 3'd2,
      S_CLR   = 3'd3,
      S_DONE  = 3'd4
   } state_e;

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   shift_q, shift_d;
   logic [BIT_W-1:0]   bit_q,   bit_d;
   logic [PH_W-1:0]    phase_q, phase_d;
   logic               half_q,  half_d;

   logic               phase_tc;

   assign phase_tc = (phase_q == '0);

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= S_IDLE;
         shift_q <= '0;
         bit_q   <= '0;
         phase_q <= '0;
         half_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         bit_q   <= bit_d;
         phase_q <= phase_d;
         half_q  <= half_d;
      end
   end

   // Phase is a down-counter; half_q selects the low/high half of a bit (or of a clear).
   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      bit_d   = bit_q;
      phase_d = phase_q;
      half_d  = half_q;
      unique case (state_q)
         S_IDLE: begin
            if (ctl.clear) begin
               state_d = S_CLR;
               phase_d = PH_LOAD;
               half_d  = 1'b0;
            end else if (ctl.start) begin
               state_d = S_SHIFT;
               shift_d = ctl.data;
               bit_d   = BIT_LOAD;
               phase_d = PH_LOAD;
               half_d  = 1'b0;
            end
         end
         S_SHIFT: begin
            if (!phase_tc) begin
               phase_d = phase_q - PH_W'(1);
            end else begin
               phase_d = PH_LOAD;
               half_d  = ~half_q;
               if (half_q) begin
                  // The last bit is not shifted out so SER holds it through LATCH.
                  if (bit_q == '0) begin
                     state_d = S_LATCH;
                  end else begin
                     bit_d   = bit_q - BIT_W'(1);
                     shift_d = shift_q << 1;
                  end
               end
            end
         end
         S_LATCH: begin
            if (!phase_tc) begin
               phase_d = phase_q - PH_W'(1);
            end else begin
               state_d = S_DONE;
               phase_d = '0;
            end
         end
         S_CLR: begin
            if (!phase_tc) begin
               phase_d = phase_q - PH_W'(1);
            end else if (!half_q) begin
               phase_d = PH_LOAD;
               half_d  = 1'b1;
            end else begin
               state_d = S_DONE;
               phase_d = '0;
               half_d  = 1'b0;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            phase_d = '0;
            half_d  = 1'b0;
         end
         default: begin
            state_d = S_IDLE;
            phase_d = '0;
            half_d  = 1'b0;
         end
      endcase
   end

   always_comb begin
      ctl.busy    = 1'b0;
      ctl.done    = 1'b0;
      ctl.ser     = 1'b0;
      ctl.srclk   = 1'b0;
      ctl.rclk    = 1'b0;
      ctl.srclr_n = 1'b1;
      unique case (state_q)
         S_IDLE: begin
         end
         S_SHIFT: begin
            ctl.busy  = 1'b1;
            ctl.ser   = shift_q[WIDTH-1];
            ctl.srclk = half_q;
         end
         S_LATCH: begin
            ctl.busy = 1'b1;
            ctl.ser  = shift_q[WIDTH-1];
            ctl.rclk = 1'b1;
         end
         S_CLR: begin
            // SRCLR releases in the same cycle RCLK rises, so RCLK never rises under clear.
            ctl.busy    = 1'b1;
            ctl.srclr_n = half_q;
            ctl.rclk    = half_q;
         end
         S_DONE: begin
            ctl.busy = 1'b1;
            ctl.done = 1'b1;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_hc595_driver.sv
// Bench for hc595_driver: a behavioural '595 chip model watches the pins and
// its latched outputs are compared with the words sent, plus timing counts.
module tb_hc595_driver;

   localparam int W   = 8;
   localparam int CD  = 2;
   localparam int TXN = 2 * CD * W + CD + 1;
   localparam int CLN = 2 * CD + 1;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   hc595_driver_if #(.WIDTH(W)) a_if ();
   hc595_driver_if #(.WIDTH(1)) b_if ();

   hc595_driver #(.WIDTH(W), .CLK_DIV(CD)) dut_a (
      .clk_i   (clk),
      .reset_i (rst),
      .ctl     (a_if.slave)
   );

   hc595_driver #(.WIDTH(1), .CLK_DIV(1)) dut_b (
      .clk_i   (clk),
      .reset_i (rst),
      .ctl     (b_if.slave)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // '595 model and pin statistics for the 8-bit instance
   logic [W-1:0] chip_sr  = '0;
   logic [W-1:0] chip_out = '0;
   logic p_srclk = 1'b0, p_rclk = 1'b0, p_ser = 1'b0, p_ser2 = 1'b0;
   int edges = 0, rrise = 0, busy_cnt = 0, done_cnt = 0, done_pos = 0;
   int viol = 0, idle_run = 0, last_gap = 0;

   always @(negedge clk) begin
      if (a_if.srclk && !p_srclk) begin
         chip_sr = {chip_sr[W-2:0], p_ser};
         edges++;
         if (p_ser !== p_ser2) viol++;
      end
      if (!a_if.srclr_n) chip_sr = '0;
      if (a_if.rclk && !p_rclk) begin
         chip_out = chip_sr;
         rrise++;
         if (!a_if.srclr_n) viol++;
      end
      if (a_if.srclk && a_if.rclk) viol++;
      if (a_if.busy) begin
         busy_cnt++;
         if (idle_run > 0) last_gap = idle_run;
         idle_run = 0;
      end else begin
         idle_run++;
      end
      if (a_if.done) begin
         done_cnt++;
         done_pos = busy_cnt;
         if (!a_if.busy) viol++;
      end
      p_ser2  = p_ser;
      p_ser   = a_if.ser;
      p_srclk = a_if.srclk;
      p_rclk  = a_if.rclk;
   end

   // Statistics for the 1-bit instance
   logic b_sr = 1'b0, b_out = 1'b0, bp_srclk = 1'b0, bp_rclk = 1'b0, bp_ser = 1'b0;
   int b_busy = 0, b_done = 0, b_pos = 0, b_shi = 0, b_ser_hi = 0, b_rhi = 0;

   always @(negedge clk) begin
      if (b_if.srclk && !bp_srclk) b_sr = bp_ser;
      if (!b_if.srclr_n) b_sr = 1'b0;
      if (b_if.rclk && !bp_rclk) b_out = b_sr;
      if (b_if.srclk) begin
         b_shi++;
         if (b_if.ser) b_ser_hi++;
      end
      if (b_if.rclk) b_rhi++;
      if (b_if.busy) b_busy++;
      if (b_if.done) begin
         b_done++;
         b_pos = b_busy;
      end
      bp_srclk = b_if.srclk;
      bp_rclk  = b_if.rclk;
      bp_ser   = b_if.ser;
   end

   int s_busy, s_edges, s_rrise, s_done;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic snap();
      s_busy  = busy_cnt;
      s_edges = edges;
      s_rrise = rrise;
      s_done  = done_cnt;
   endtask

   task automatic wait_done(input int target);
      int k = 0;
      while (done_cnt < target && k < 400) begin
         cyc();
         k++;
      end
      if (done_cnt < target) check("done_timeout", done_cnt, target);
   endtask

   task automatic send_a(input logic [W-1:0] d);
      snap();
      a_if.data  = d;
      a_if.start = 1'b1;
      cyc();
      a_if.start = 1'b0;
      wait_done(s_done + 1);
      repeat (2) cyc();
   endtask

   task automatic check_txn(input string tag, input logic [W-1:0] d);
      check({tag, "_busy"},  busy_cnt - s_busy, TXN);
      check({tag, "_edges"}, edges - s_edges, W);
      check({tag, "_rclk"},  rrise - s_rrise, 1);
      check({tag, "_done"},  done_cnt - s_done, 1);
      check({tag, "_dpos"},  done_pos - s_busy, TXN);
      check({tag, "_out"},   chip_out, d);
   endtask

   task automatic check_rest(input string tag);
      check({tag, "_busy"},    a_if.busy, 1'b0);
      check({tag, "_done"},    a_if.done, 1'b0);
      check({tag, "_ser"},     a_if.ser, 1'b0);
      check({tag, "_srclk"},   a_if.srclk, 1'b0);
      check({tag, "_rclk"},    a_if.rclk, 1'b0);
      check({tag, "_srclr_n"}, a_if.srclr_n, 1'b1);
   endtask

   initial begin
      logic [W-1:0] rnd;
      int k;
      rst        = 1'b1;
      a_if.data  = '0;
      a_if.start = 1'b0;
      a_if.clear = 1'b0;
      b_if.data  = '0;
      b_if.start = 1'b0;
      b_if.clear = 1'b0;
      repeat (3) cyc();
      check_rest("reset");
      rst = 1'b0;
      repeat (2) cyc();

      // Basic transfer
      send_a(8'hA5);
      check_txn("a5", 8'hA5);

      // Clear wins over Start
      snap();
      a_if.data  = 8'hFF;
      a_if.start = 1'b1;
      a_if.clear = 1'b1;
      cyc();
      a_if.start = 1'b0;
      a_if.clear = 1'b0;
      wait_done(s_done + 1);
      repeat (2) cyc();
      check("clr_busy",  busy_cnt - s_busy, CLN);
      check("clr_edges", edges - s_edges, 0);
      check("clr_rclk",  rrise - s_rrise, 1);
      check("clr_dpos",  done_pos - s_busy, CLN);
      check("clr_out",   chip_out, 8'h00);

      // Start pulses while busy are ignored
      snap();
      a_if.data  = 8'h3C;
      a_if.start = 1'b1;
      cyc();
      a_if.start = 1'b0;
      repeat (4) cyc();
      a_if.start = 1'b1;
      cyc();
      a_if.start = 1'b0;
      repeat (14) cyc();
      a_if.start = 1'b1;
      cyc();
      a_if.start = 1'b0;
      wait_done(s_done + 1);
      repeat (5) cyc();
      check_txn("ign", 8'h3C);

      // Start held: back-to-back with one idle cycle between
      snap();
      a_if.data  = 8'h01;
      a_if.start = 1'b1;
      cyc();
      a_if.data  = 8'h80;
      wait_done(s_done + 1);
      check("b2b_out1", chip_out, 8'h01);
      repeat (3) cyc();
      check("b2b_gap", last_gap, 1);
      wait_done(s_done + 2);
      a_if.start = 1'b0;
      repeat (3) cyc();
      check("b2b_out2",  chip_out, 8'h80);
      check("b2b_busy",  busy_cnt - s_busy, 2 * TXN);
      check("b2b_edges", edges - s_edges, 2 * W);
      check("b2b_done",  done_cnt - s_done, 2);

      // Reset mid-transfer discards the word and never latches
      send_a(8'h0F);
      check("pre_out", chip_out, 8'h0F);
      snap();
      a_if.data  = 8'hF0;
      a_if.start = 1'b1;
      cyc();
      a_if.start = 1'b0;
      repeat (11) cyc();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      check_rest("midrst");
      snap();
      repeat (40) cyc();
      check("midrst_rclk", rrise - s_rrise, 0);
      check("midrst_idle", busy_cnt - s_busy, 0);
      check("midrst_out",  chip_out, 8'h0F);
      send_a(8'hF0);
      check_txn("after_rst", 8'hF0);

      // Random words
      for (int i = 0; i < 6; i++) begin
         rnd = W'($urandom);
         send_a(rnd);
         check("rnd_out",  chip_out, rnd);
         check("rnd_busy", busy_cnt - s_busy, TXN);
         check("rnd_edges", edges - s_edges, W);
      end

      // One-bit chain, CLK_DIV=1
      b_if.data  = 1'b1;
      b_if.start = 1'b1;
      cyc();
      b_if.start = 1'b0;
      k = 0;
      while (b_done < 1 && k < 50) begin
         cyc();
         k++;
      end
      repeat (2) cyc();
      check("w1_done",   b_done, 1);
      check("w1_busy",   b_busy, 4);
      check("w1_dpos",   b_pos, 4);
      check("w1_srclk",  b_shi, 1);
      check("w1_ser_hi", b_ser_hi, 1);
      check("w1_rclk",   b_rhi, 1);
      check("w1_out",    b_out, 1'b1);

      check("pin_rules", viol, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
